// File: rtl/frecuenciometro_pkg.sv
// rtl/frecuenciometro_pkg.sv - shared frequency meter constants and FSM state encoding
package frecuenciometro_pkg;

  localparam int MAX_COUNT_DEF = 999_999;
  localparam int W_DEF         = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    GATE  = 2'd2,
    LATCH = 2'd3
  } estado_t;

endpackage

// File: rtl/detector_flanco.sv
// rtl/detector_flanco.sv - two-flop synchronizer plus rising-edge detector
module detector_flanco (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulso
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  always_comb begin
    sync1_d = in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign pulso = sync2_q & ~prev_q;

endmodule

// File: rtl/control_medicion.sv
// rtl/control_medicion.sv - gated edge counter: counts sig_in rising edges per window
module control_medicion
  import frecuenciometro_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int GATE_CYCLES = CLK_HZ,
  parameter int MAX_COUNT   = MAX_COUNT_DEF,
  parameter int W           = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sig_in,
  input  logic         enable,
  output logic [W-1:0] medicion,
  output logic         valida,
  output logic         overflow,
  output logic         ocupado
);

  localparam int             TW     = $clog2(GATE_CYCLES + 1);
  localparam logic [W-1:0]  MAX_W  = W'(MAX_COUNT);
  localparam logic [W-1:0]  ONE_W  = W'(1);
  localparam logic [TW-1:0] GATE_T = TW'(GATE_CYCLES);
  localparam logic [TW-1:0] ONE_T  = TW'(1);

  estado_t       estado_q, estado_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          sat_q, sat_d;
  logic [W-1:0]  medicion_q, medicion_d;
  logic          overflow_q, overflow_d;
  logic          valida_q, valida_d;
  logic          pulso;

  detector_flanco u_detector (
    .clk   (clk),
    .rst   (rst),
    .in    (sig_in),
    .pulso (pulso)
  );

  always_comb begin
    estado_d   = estado_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    sat_d      = sat_q;
    medicion_d = medicion_q;
    overflow_d = overflow_q;
    valida_d   = 1'b0;
    case (estado_q)
      IDLE: begin
        if (enable) estado_d = CLEAR;
      end
      CLEAR: begin
        // timer is armed with the window length and counts down to the last gate cycle
        cnt_d    = '0;
        sat_d    = 1'b0;
        timer_d  = GATE_T;
        estado_d = enable ? GATE : IDLE;
      end
      GATE: begin
        if (!enable) begin
          estado_d = IDLE;
        end else begin
          if (pulso) begin
            if (cnt_q == MAX_W) sat_d = 1'b1;
            else                cnt_d = cnt_q + ONE_W;
          end
          if (timer_q != '0) timer_d = timer_q - ONE_T;
          if (timer_q <= ONE_T) estado_d = LATCH;
        end
      end
      LATCH: begin
        medicion_d = cnt_q;
        overflow_d = sat_q;
        valida_d   = 1'b1;
        estado_d   = enable ? CLEAR : IDLE;
      end
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q   <= IDLE;
      cnt_q      <= '0;
      timer_q    <= '0;
      sat_q      <= 1'b0;
      medicion_q <= '0;
      overflow_q <= 1'b0;
      valida_q   <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      sat_q      <= sat_d;
      medicion_q <= medicion_d;
      overflow_q <= overflow_d;
      valida_q   <= valida_d;
    end
  end

  assign medicion = medicion_q;
  assign overflow = overflow_q;
  assign valida   = valida_q;
  assign ocupado  = (estado_q != IDLE);

endmodule
